// File: rtl/cla_nibble_sequencer_if.sv
// Operand, result and adder-side signal bundle for cla_nibble_sequencer.
// master = the sequencer itself, slave = the operand source / result sink / adder.
interface cla_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_wide;
    logic [WIDTH-1:0] b_wide;
    logic             carry_in;

    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_s;
    logic             add_cout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_wide;
    logic             carry_out;
    logic             busy;

    modport master (
        input  in_valid, a_wide, b_wide, carry_in,
        input  add_s, add_cout,
        input  out_ready,
        output in_ready,
        output add_a, add_b, add_cin,
        output out_valid, sum_wide, carry_out, busy
    );

    modport slave (
        output in_valid, a_wide, b_wide, carry_in,
        output add_s, add_cout,
        output out_ready,
        input  in_ready,
        input  add_a, add_b, add_cin,
        input  out_valid, sum_wide, carry_out, busy
    );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Runs a WIDTH-bit add as NIB sequential nibble passes through a registered 4-bit adder.
// Result after NIB*(ADD_LAT+1) edges; holds the result in DONE until out_ready, in_ready low while busy.
module cla_nibble_sequencer #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    cla_nibble_sequencer_if.master   bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int CW  = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_nxt;
    logic [CW-1:0]    cnt;
    logic             last_nib;

    assign idx_nxt      = idx + 1'b1;
    assign last_nib     = (idx == IW'(NIB - 1));
    assign bus.sum_wide = sum_reg;

    // add_cin doubles as the running carry register: it is loaded with
    // carry_in on accept and with add_cout at every inter-nibble capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            idx           <= '0;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.carry_out <= 1'b0;
            bus.add_a     <= 4'd0;
            bus.add_b     <= 4'd0;
            bus.add_cin   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        a_reg        <= bus.a_wide;
                        b_reg        <= bus.b_wide;
                        idx          <= '0;
                        bus.add_a    <= bus.a_wide[3:0];
                        bus.add_b    <= bus.b_wide[3:0];
                        bus.add_cin  <= bus.carry_in;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CW'(ADD_LAT - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        sum_reg[{idx, 2'b00} +: 4] <= bus.add_s;
                        if (last_nib) begin
                            bus.carry_out <= bus.add_cout;
                            bus.out_valid <= 1'b1;
                            bus.add_a     <= 4'd0;
                            bus.add_b     <= 4'd0;
                            bus.add_cin   <= 1'b0;
                            state         <= DONE;
                        end else begin
                            idx         <= idx_nxt;
                            bus.add_a   <= a_reg[{idx_nxt, 2'b00} +: 4];
                            bus.add_b   <= b_reg[{idx_nxt, 2'b00} +: 4];
                            bus.add_cin <= bus.add_cout;
                            state       <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer with a behavioural 2-stage registered 4-bit adder.
`timescale 1ns/1ps
module tb_cla_nibble_sequencer;
    localparam int WIDTH   = 16;
    localparam int ADD_LAT = 2;
    localparam int NIB     = WIDTH / 4;
    localparam int LAT     = NIB * (ADD_LAT + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cla_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

    cla_nibble_sequencer #(.WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Adder: samples inputs at one edge, presents sum/carry after the next.
    logic [4:0] s1, s2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'd0, bus.add_cin};
            s2 <= s1;
        end
    end
    assign bus.add_s    = s2[3:0];
    assign bus.add_cout = s2[4];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input int stall, input logic [15:0] exp_sum, input logic exp_cout);
        logic       c;
        logic [4:0] ns;
        logic [3:0] an, bn;
        int         n, w, k;
        bus.out_ready = (stall == 0);
        w = 0;
        while (!bus.in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a_wide   = a;
        bus.b_wide   = b;
        bus.carry_in = cin;
        tick();
        bus.in_valid = 1'b0;
        bus.a_wide   = 16'($urandom);
        bus.b_wide   = 16'($urandom);
        bus.carry_in = 1'($urandom);
        chk("busy_after_accept", bus.busy, 1);
        chk("in_ready_after_accept", bus.in_ready, 0);
        c = cin;
        n = 0;
        while (!bus.out_valid && n < LAT + 10) begin
            tick();
            n++;
            if ((n % (ADD_LAT + 1)) == 1 && (n / (ADD_LAT + 1)) < NIB) begin
                k  = n / (ADD_LAT + 1);
                an = a[4*k +: 4];
                bn = b[4*k +: 4];
                chk("add_a_nibble", bus.add_a, an);
                chk("add_b_nibble", bus.add_b, bn);
                chk("add_cin_nibble", bus.add_cin, c);
                ns = {1'b0, an} + {1'b0, bn} + {4'd0, c};
                c  = ns[4];
            end
        end
        chk("latency", n, LAT);
        chk("sum_wide", bus.sum_wide, exp_sum);
        chk("carry_out", bus.carry_out, exp_cout);
        chk("in_ready_in_done", bus.in_ready, 0);
        chk("add_a_zero_in_done", {bus.add_a, bus.add_b, bus.add_cin}, 0);
        for (int s = 0; s < stall; s++) begin
            bus.in_valid = 1'b1;
            bus.a_wide   = 16'($urandom);
            tick();
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_sum_stable", {bus.carry_out, bus.sum_wide}, {exp_cout, exp_sum});
            chk("stall_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("out_valid_cleared", bus.out_valid, 0);
        chk("in_ready_after_out", bus.in_ready, 1);
        chk("busy_after_out", bus.busy, 0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        int          stall;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] rs;

        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 0, 16'h2201, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 0, 16'h0000, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1};
        vecs[3] = '{16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 5, 16'h8000, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 2, 16'hFFFF, 1'b1};
        vecs[6] = '{16'h0F0F, 16'hF0F0, 1'b0, 0, 16'hFFFF, 1'b0};

        bus.in_valid  = 1'b0;
        bus.a_wide    = '0;
        bus.b_wide    = '0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b1;

        tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", {bus.carry_out, bus.sum_wide}, 0);
        chk("rst_add", {bus.add_a, bus.add_b, bus.add_cin}, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 7; i++)
            run_txn(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall,
                    vecs[i].exp_sum, vecs[i].exp_cout);

        // Reset in the middle of an operation discards it.
        bus.in_valid = 1'b1;
        bus.a_wide   = 16'hAAAA;
        bus.b_wide   = 16'h5555;
        bus.carry_in = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_add", {bus.add_a, bus.add_b, bus.add_cin}, 0);
        chk("midrst_busy", bus.busy, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_in_ready", bus.in_ready, 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        chk("midrst_no_out_valid", pulses, 0);
        run_txn(16'h0003, 16'h0004, 1'b0, 0, 16'h0007, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            run_txn(ra, rb, rc, $urandom_range(0, 3), rs[15:0], rs[16]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
